// File: rtl/alu_issue_stage.sv
// alu_issue_stage: three-state issue stage (IDLE/EXECUTE/WRITEBACK) in front of a combinational ALU
// Ports:
//   clk, rstN                         clock, asynchronous active-low reset
//   instrValid, instrData, instrReady instruction offer and acceptance
//   aluFunction, vectorA, vectorB, inputCarry       drive to the ALU (EXECUTE only)
//   aluResult, outputCarry, overflow, zero          combinational ALU return
//   wbValid, wbAddr, wbData           writeback strobe, destination, value
//   flagCarry, flagZero, flagOverflow registered status flags
//   illegalOp                         one-cycle unsupported-opcode pulse
//   rdAddr, rdData                    combinational register-file read port
module alu_issue_stage #(
    parameter int BITS  = 8,
    parameter int ALUOP = 4
) (
    input  logic             clk,
    input  logic             rstN,
    input  logic             instrValid,
    input  logic [15:0]      instrData,
    output logic             instrReady,
    output logic [ALUOP-1:0] aluFunction,
    output logic [BITS-1:0]  vectorA,
    output logic [BITS-1:0]  vectorB,
    output logic             inputCarry,
    input  logic [BITS-1:0]  aluResult,
    input  logic             outputCarry,
    input  logic             overflow,
    input  logic             zero,
    output logic             wbValid,
    output logic [2:0]       wbAddr,
    output logic [BITS-1:0]  wbData,
    output logic             flagCarry,
    output logic             flagZero,
    output logic             flagOverflow,
    output logic             illegalOp,
    input  logic [2:0]       rdAddr,
    output logic [BITS-1:0]  rdData
);
    typedef enum logic [1:0] {IDLE, EXECUTE, WRITEBACK} state_t;
    state_t state, state_next;
    logic [15:0] instr;
    logic [BITS-1:0] regs [8];
    logic [BITS-1:0] result;
    logic alu_c, alu_z, alu_v;
    logic [3:0] op;
    logic [2:0] rd, ra, rb;
    logic illegal, writes_cv, writes_z;
    assign op = instr[15:12];
    assign rd = instr[11:9];
    assign ra = instr[8:6];
    assign rb = instr[5:3];
    assign illegal = op == 4'd0 || op >= 4'd12;
    assign writes_cv = op == 4'd1 || op == 4'd2;
    assign writes_z = !illegal && op != 4'd6 && op != 4'd7;
    assign wbAddr = rd;
    assign wbData = result;
    assign rdData = regs[rdAddr];
    always_comb begin
        state_next = IDLE;
        instrReady = 1'b0;
        aluFunction = '0;
        vectorA = '0;
        vectorB = '0;
        inputCarry = 1'b0;
        wbValid = 1'b0;
        illegalOp = 1'b0;
        case (state)
            IDLE: begin
                instrReady = 1'b1;
                state_next = instrValid ? EXECUTE : IDLE;
            end
            EXECUTE: begin
                state_next = WRITEBACK;
                aluFunction = ALUOP'(op);
                vectorA = regs[ra];
                vectorB = regs[rb];
                inputCarry = op == 4'd2 && flagCarry;
            end
            WRITEBACK: begin
                wbValid = !illegal;
                illegalOp = illegal;
            end
            default: ;
        endcase
    end
    // ALU flags are held from EXECUTE and only committed with the register write
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= IDLE;
            instr <= '0;
            result <= '0;
            alu_c <= 1'b0;
            alu_z <= 1'b0;
            alu_v <= 1'b0;
            flagCarry <= 1'b0;
            flagZero <= 1'b0;
            flagOverflow <= 1'b0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            state <= state_next;
            if (instrReady && instrValid) instr <= instrData;
            if (state == EXECUTE) begin
                result <= op == 4'd6 ? BITS'(instr[7:0]) : op == 4'd7 ? regs[ra] : aluResult;
                alu_c <= outputCarry;
                alu_z <= zero;
                alu_v <= overflow;
            end
            if (state == WRITEBACK && !illegal) begin
                regs[rd] <= result;
                if (writes_cv) begin
                    flagCarry <= alu_c;
                    flagOverflow <= alu_v;
                end
                if (writes_z) flagZero <= alu_z;
            end
        end
    end
endmodule
